// File: rtl/psum_fifo.sv
// Partial-sum FIFO between adder-tree passes: stores row partial sums, feeds them
// back for accumulation, and drains final sums on the last pass.
module psum_fifo #(
    parameter int DATA_WIDTH = 25,
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         first_pass,
    input  logic                         last_pass,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         rd_en,
    output logic signed [DATA_WIDTH-1:0] fifo_data,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_W:0]              count,
    output logic                         err
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

    logic signed [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              fp;
    logic              lp;

    logic fp_eff;
    logic lp_eff;
    logic is_full;
    logic is_empty;
    logic wr_req;
    logic rd_req;
    logic wr_ok;
    logic rd_ok;
    logic wr_ovf;
    logic rd_unf;
    logic drain;

    // A start pulse applies its flags to the transfer in the same cycle.
    always_comb begin
        fp_eff   = start ? first_pass : fp;
        lp_eff   = start ? last_pass  : lp;
        is_full  = (count == FULL_CNT);
        is_empty = (count == '0);
        wr_req   = in_valid && !lp_eff;
        rd_req   = rd_en && !fp_eff;
        wr_ok    = wr_req && !is_full;
        wr_ovf   = wr_req && is_full;
        rd_ok    = rd_req && !is_empty;
        rd_unf   = rd_req && is_empty;
        drain    = in_valid && lp_eff;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fp <= 1'b1;
            lp <= 1'b0;
        end else if (start) begin
            fp <= first_pass;
            lp <= last_pass;
        end
    end

    // Full/empty are judged on the pre-update count, so a simultaneous read never
    // makes room for (or supplies data to) the write in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
            if (wr_ovf || rd_unf)
                err <= 1'b1;
        end
    end

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_data <= '0;
        end else if (rd_en) begin
            fifo_data <= rd_ok ? mem[rd_ptr] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= drain;
            if (drain)
                out_data <= in_data;
        end
    end

endmodule

// File: tb/tb_psum_fifo.sv
// Scoreboard bench for psum_fifo: a queue-based model predicts feedback and drain
// data; a monitor compares them against the DUT every cycle.
module tb_psum_fifo;

    localparam int DW    = 25;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 first_pass;
    logic                 last_pass;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 rd_en;
    logic signed [DW-1:0] fifo_data;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic [AW:0]          count;
    logic                 err;

    psum_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .first_pass(first_pass),
        .last_pass(last_pass), .in_valid(in_valid), .in_data(in_data),
        .rd_en(rd_en), .fifo_data(fifo_data), .out_valid(out_valid),
        .out_data(out_data), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: stored entries, pass flags, sticky error, expected responses.
    logic signed [DW-1:0] mq[$];
    logic signed [DW-1:0] exp_fifo[$];
    logic signed [DW-1:0] exp_out[$];
    logic signed [DW-1:0] m_last = '0;
    bit m_fp  = 1'b1;
    bit m_lp  = 1'b0;
    bit m_err = 1'b0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_fifo.delete();
        exp_out.delete();
        m_last = '0;
        m_fp   = 1'b1;
        m_lp   = 1'b0;
        m_err  = 1'b0;
    endtask

    // One clock of stimulus; the model advances using the occupancy seen before the edge.
    task automatic step(input bit s, input bit f, input bit l, input bit iv,
                        input logic signed [DW-1:0] d, input bit rd);
        int sz0;
        start = s; first_pass = f; last_pass = l;
        in_valid = iv; in_data = d; rd_en = rd;
        @(posedge clk);
        if (s) begin
            m_fp = f;
            m_lp = l;
        end
        sz0 = mq.size();
        if (rd) begin
            if (m_fp)
                exp_fifo.push_back('0);
            else if (sz0 > 0)
                exp_fifo.push_back(mq.pop_front());
            else begin
                exp_fifo.push_back('0);
                m_err = 1'b1;
            end
        end
        if (iv) begin
            if (m_lp)
                exp_out.push_back(d);
            else if (sz0 < DEPTH)
                mq.push_back(d);
            else
                m_err = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0);
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (exp_fifo.size() > 0) begin
                m_last = exp_fifo.pop_front();
                check("fifo_data", fifo_data, m_last);
            end else begin
                check("fifo_hold", fifo_data, m_last);
            end
            check("out_valid", out_valid, exp_out.size() > 0);
            if (exp_out.size() > 0) begin
                logic signed [DW-1:0] e;
                e = exp_out.pop_front();
                if (out_valid) check("out_data", out_data, e);
            end
            check("count", count, mq.size());
            check("err", err, m_err);
        end
    end

    initial begin
        rst = 1'b1;
        start = 0; first_pass = 0; last_pass = 0;
        in_valid = 0; in_data = '0; rd_en = 0;
        repeat (3) @(negedge clk);
        check("rst_count", count, 0);
        check("rst_fifo", fifo_data, 0);
        check("rst_err", err, 0);
        check("rst_oval", out_valid, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // First pass feeds back zeros.
        step(1, 1, 0, 0, '0, 0);
        repeat (3) step(0, 0, 0, 0, '0, 1);
        idle(1);

        // Store then read back on a later pass.
        step(0, 0, 0, 1, 25'sd5, 0);
        step(0, 0, 0, 1, -25'sd3, 0);
        step(0, 0, 0, 1, 25'sd7, 0);
        step(1, 0, 0, 0, '0, 0);
        repeat (3) step(0, 0, 0, 0, '0, 1);
        idle(1);

        // Fill, overflow by one, then drain in order.
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, DW'($urandom), 0);
        step(0, 0, 0, 1, 25'sd1234, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, '0, 1);

        // Empty read with simultaneous write: underflow, write kept.
        step(0, 0, 0, 1, 25'sd9, 1);
        step(0, 0, 0, 0, '0, 1);
        idle(1);

        // Last pass drains to out_data.
        step(0, 0, 0, 1, 25'sd11, 0);
        step(1, 0, 1, 0, '0, 0);
        step(0, 0, 0, 1, -25'sd100, 0);
        idle(2);

        // Asynchronous reset mid-stream with four stored entries.
        step(1, 0, 0, 0, '0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, DW'(i + 40), 0);
        check("pre_rst_count", count, 4);
        #2 rst = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_fifo", fifo_data, 0);
        check("arst_err", err, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // Randomised passes, including start colliding with transfers.
        for (int i = 0; i < 2000; i++) begin
            bit s;
            s = ($urandom_range(15) == 0);
            step(s, $urandom_range(3) == 0, $urandom_range(3) == 0,
                 $urandom_range(1) == 1, DW'($urandom), $urandom_range(1) == 1);
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/psum_fifo.md
PSUM_FIFO -- requirements
Module: psum_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 25, is the partial-sum width, equal to the adder-tree width.
REQ-002 Parameter DEPTH, default 64, is the maximum number of partial sums held per row; it SHALL be a power of two.
REQ-003 Parameter ADDR_W, default 6, is the pointer width; it SHALL equal log2(DEPTH).
REQ-004 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  is the reset; it SHALL be asynchronous and active-high.
REQ-006 start  input  1  is a one-cycle pulse that begins a pass and latches the pass flags.
REQ-007 first_pass  input  1  is sampled at start; when 1, no prior partial sum exists and zeros SHALL be fed back.
REQ-008 last_pass  input  1  is sampled at start; when 1, results SHALL be drained to out_data instead of being stored.
REQ-009 in_valid  input  1  qualifies in_data.
REQ-010 in_data  input  DATA_WIDTH  is the signed sum from the adder-tree output.
REQ-011 rd_en  input  1  requests the next stored partial sum for the adder tree.
REQ-012 fifo_data  output  DATA_WIDTH  is the signed partial sum returned to the adder tree.
REQ-013 out_valid  output  1  qualifies out_data.
REQ-014 out_data  output  DATA_WIDTH  is the signed final sum produced during the last pass.
REQ-015 count  output  ADDR_W+1  is the number of stored entries.
REQ-016 err  output  1  is a sticky overflow/underflow flag.

Function
REQ-017 Storage SHALL be a DEPTH-entry circular buffer with write pointer wr_ptr and read pointer rd_ptr; both pointers SHALL wrap from DEPTH-1 to 0.
REQ-018 On start, the block SHALL latch fp := first_pass and lp := last_pass, and SHALL NOT clear pointers or count.
  - This lets a pass read the entries written by the previous pass.
REQ-019 On in_valid with lp=0 and count<DEPTH, the block SHALL write in_data at wr_ptr and increment wr_ptr.
REQ-020 On in_valid with lp=0 and count==DEPTH, the block SHALL drop the write, leave the pointers unchanged and set err.
REQ-021 On in_valid with lp=1, the block SHALL NOT write memory; out_data SHALL equal in_data and out_valid SHALL be 1 in the following cycle (latency 1).
REQ-022 out_valid SHALL be 0 in every cycle that is not such a response.
REQ-023 On rd_en with fp=1, fifo_data SHALL become 0 one cycle later; memory, rd_ptr and count SHALL be unchanged.
REQ-024 On rd_en with fp=0 and count>0, fifo_data SHALL become mem[rd_ptr] one cycle later (registered, latency 1), and rd_ptr SHALL increment.
REQ-025 On rd_en with fp=0 and count==0, fifo_data SHALL become 0, rd_ptr SHALL be unchanged and err SHALL be set.
REQ-026 fifo_data SHALL hold its last value in cycles without rd_en.
REQ-027 count SHALL increment on an accepted write only, decrement on an accepted read only, and be unchanged when both occur in the same cycle.
REQ-028 A read and a write in the same cycle SHALL both be honoured.
  - There is no write-to-read bypass: with count==0, the read underflows and the write is stored.
  - With count==DEPTH, the read is accepted, the write is dropped and err is set; count is evaluated before the cycle's update.
REQ-029 Arithmetic SHALL be pass-through only: no sign extension and no truncation; all data is DATA_WIDTH signed.
REQ-030 start coinciding with in_valid or rd_en SHALL apply the newly latched flags to that same cycle's transfer.
REQ-031 err SHALL clear only on rst.

Reset
REQ-032 While rst=1, the block SHALL hold wr_ptr=0, rd_ptr=0, count=0, fp=1, lp=0, fifo_data=0, out_data=0, out_valid=0 and err=0.
REQ-033 Asserting rst mid-pass SHALL discard all stored entries; memory contents need not be cleared.
REQ-034 The first edge after rst deasserts SHALL operate normally.

Verification
REQ-035 Reset, then start with first_pass=1, then 3x rd_en -> fifo_data=0 on each following cycle; count=0; err=0.
REQ-036 first_pass=1, write 5,-3,7 -> count=3; start with first_pass=0, then 3x rd_en -> fifo_data 5, -3, 7 at latency 1; count=0.
REQ-037 Fill DEPTH entries, then one more in_valid -> write dropped, err=1, count stays DEPTH; after reading all entries, data order is intact.
REQ-038 count=0, fp=0, simultaneous rd_en and in_valid with 9 -> fifo_data=0, err=1, count=1; next rd_en -> fifo_data=9.
REQ-039 start with last_pass=1, in_valid with -100 -> out_valid=1 and out_data=-100 one cycle later; count unchanged.
REQ-040 rst pulse with count=4 mid-stream -> count=0, fifo_data=0, err=0, within the same cycle (asynchronous).
